// File: rtl/shift_request_queue_pkg.sv
// Shared types and helpers for the shift request queue.
// Defines the request bundle and shift-amount range helpers.
package shift_pkg;

   localparam int SHIFT_W   = 11;
   localparam int SHIFT_S_W = 4;

   localparam logic [SHIFT_S_W-1:0] SHIFT_W_S = SHIFT_S_W'(SHIFT_W);

   typedef struct packed {
      logic [SHIFT_W-1:0]   a;
      logic [SHIFT_S_W-1:0] s;
   } shift_req_t;

   // True when the amount selects a real bit position.
   function automatic logic in_range(input logic [SHIFT_S_W-1:0] s);
      return s < SHIFT_W_S;
   endfunction

   // min(s, SHIFT_W): keeps the select inside the operand.
   function automatic logic [SHIFT_S_W-1:0] clamp_amount(
      input logic [SHIFT_S_W-1:0] s
   );
      return in_range(s) ? s : SHIFT_W_S;
   endfunction

endpackage

// File: rtl/shift_request_queue_fifo.sv
// Request FIFO: storage, pointers, occupancy, full/empty flags.
// Ports: clk, rst (sync, active-low), push/wdata, pop/rdata, count, full, empty.
module shift_fifo
   import shift_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  shift_req_t    wdata,
   input  logic          pop,
   output shift_req_t    rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   shift_req_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Payload storage needs no reset; occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/shift_request_queue.sv
// Queues {operand, amount} requests, issues the head to a logical right
// shifter and holds the result in a handshaked output register.
// Ports: clk, rst (sync, active-low); in_valid/in_ready/in_a/in_s request
// side; out_valid/out_ready/out_y/out_sticky result side; count = FIFO fill.
// Option: SHIFT_STICKY_EN enables the registered shifted-out OR (out_sticky);
// without it out_sticky is tied low.
module shift_request_queue
   import shift_pkg::*;
#(
   parameter int N     = SHIFT_W,
   parameter int S     = SHIFT_S_W,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [S-1:0]  in_s,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_y,
   output logic          out_sticky,
   output logic [CW-1:0] count
);

   shift_req_t wdata;
   shift_req_t head;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   logic [N-1:0] shifted;
   logic [N-1:0] y_next;

   // in_ready comes from registered state only, so a full queue
   // refuses a push even when it pops in the same cycle.
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = !empty && (!out_valid || out_ready);
   assign wdata    = '{a: in_a, s: in_s};

   shift_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Single shifter on the FIFO head; out-of-range amounts forced to zero.
   assign shifted = head.a >> head.s;
   assign y_next  = in_range(head.s) ? shifted : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_y     <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_y     <= y_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef SHIFT_STICKY_EN
   logic [N-1:0] mask;
   logic         sticky_next;
   logic         sticky_q;

   // At the clamp value 1<<N overflows to 0, so the mask becomes all ones.
   assign mask        = (N'(1) << clamp_amount(head.s)) - N'(1);
   assign sticky_next = |(head.a & mask);
   assign out_sticky  = sticky_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sticky_q <= 1'b0;
      end else if (pop) begin
         sticky_q <= sticky_next;
      end
   end
`else
   assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shift_request_queue.sv
// Directed self-checking bench for shift_request_queue.
// Covers reset, boundary amounts, backpressure, streaming and mid-run reset.
module tb_shift_request_queue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_a;
   logic [3:0]  in_s;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_y;
   logic        out_sticky;
   logic [2:0]  count;

   int total;
   int bad;

`ifdef SHIFT_STICKY_EN
   localparam bit STICKY_ON = 1'b1;
`else
   localparam bit STICKY_ON = 1'b0;
`endif

   shift_request_queue dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_s       (in_s),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_sticky (out_sticky),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] ref_y(input logic [10:0] a,
                                         input logic [3:0] s);
      if (s >= 4'd11) return 11'h000;
      return a >> s;
   endfunction

   function automatic logic ref_sticky(input logic [10:0] a,
                                       input logic [3:0] s);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i < int'(s)) r = r | a[i];
      end
      return STICKY_ON ? r : 1'b0;
   endfunction

   logic [10:0] t3_y [4];
   logic        t3_st [4];
   logic [3:0]  t3_s [4];
   logic [10:0] t4_a [6];
   logic [3:0]  t4_s [6];
   logic [10:0] t4_y [5];
   logic        t4_st [5];
   logic [10:0] sa [20];
   logic [3:0]  ss [20];

   initial begin
      total = 0;
      bad   = 0;

      // 1: reset held with a request present
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_a      = 11'h7FF;
      in_s      = 4'd1;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_count", 32'(count), 32'd0);
      end
      chk("rst_out_y", 32'(out_y), 32'd0);
      chk("rst_sticky", 32'(out_sticky), 32'd0);
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("post_rst_count", 32'(count), 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      // 2: single request 7FF >> 3
      in_valid = 1'b1;
      in_a     = 11'h7FF;
      in_s     = 4'd3;
      tick();
      in_valid = 1'b0;
      chk("single_count", 32'(count), 32'd1);
      chk("single_not_yet", 32'(out_valid), 32'd0);
      tick();
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_y", 32'(out_y), 32'h0FF);
      chk("single_sticky", 32'(out_sticky), 32'(STICKY_ON));
      chk("single_count0", 32'(count), 32'd0);
      tick();
      chk("single_drop", 32'(out_valid), 32'd0);
      chk("single_hold_y", 32'(out_y), 32'h0FF);

      // 3: boundary amounts on 555
      t3_s[0] = 4'd0;  t3_y[0] = 11'h555; t3_st[0] = 1'b0;
      t3_s[1] = 4'd10; t3_y[1] = 11'h001; t3_st[1] = 1'b1;
      t3_s[2] = 4'd11; t3_y[2] = 11'h000; t3_st[2] = 1'b1;
      t3_s[3] = 4'd15; t3_y[3] = 11'h000; t3_st[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a     = 11'h555;
         in_s     = t3_s[i];
         tick();
         in_valid = 1'b0;
         tick();
         chk($sformatf("bnd_valid_s%0d", t3_s[i]), 32'(out_valid), 32'd1);
         chk($sformatf("bnd_y_s%0d", t3_s[i]), 32'(out_y), 32'(t3_y[i]));
         chk($sformatf("bnd_st_s%0d", t3_s[i]), 32'(out_sticky),
             32'(t3_st[i] & STICKY_ON));
         tick();
      end

      // 4: backpressure, 6 pushes with output stalled
      t4_a[0] = 11'h700; t4_s[0] = 4'd1;
      t4_a[1] = 11'h0F0; t4_s[1] = 4'd2;
      t4_a[2] = 11'h3C3; t4_s[2] = 4'd3;
      t4_a[3] = 11'h7FF; t4_s[3] = 4'd4;
      t4_a[4] = 11'h2AA; t4_s[4] = 4'd5;
      t4_a[5] = 11'h1FF; t4_s[5] = 4'd6;
      t4_y[0] = 11'h380; t4_st[0] = 1'b0;
      t4_y[1] = 11'h03C; t4_st[1] = 1'b0;
      t4_y[2] = 11'h078; t4_st[2] = 1'b1;
      t4_y[3] = 11'h07F; t4_st[3] = 1'b1;
      t4_y[4] = 11'h015; t4_st[4] = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_a     = t4_a[i];
         in_s     = t4_s[i];
         tick();
      end
      chk("bp_full_count", 32'(count), 32'd4);
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      in_a = t4_a[5];
      in_s = t4_s[5];
      tick();
      in_valid = 1'b0;
      chk("bp_refused_count", 32'(count), 32'd4);
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_held_y", 32'(out_y), 32'(t4_y[0]));
      chk("bp_held_st", 32'(out_sticky), 32'(t4_st[0] & STICKY_ON));
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_rel_valid_%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_rel_y_%0d", i), 32'(out_y), 32'(t4_y[i]));
         chk($sformatf("bp_rel_st_%0d", i), 32'(out_sticky),
             32'(t4_st[i] & STICKY_ON));
         tick();
      end
      chk("bp_drained_valid", 32'(out_valid), 32'd0);
      chk("bp_drained_count", 32'(count), 32'd0);

      // 5: streaming 20 requests back to back
      for (int k = 0; k < 20; k++) begin
         sa[k] = 11'((k * 157 + 93) % 2048);
         ss[k] = 4'(k % 13);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1;
         in_a     = sa[k];
         in_s     = ss[k];
         tick();
         chk($sformatf("str_count_%0d", k), 32'(count), 32'd1);
         if (k >= 1) begin
            chk($sformatf("str_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("str_y_%0d", k), 32'(out_y),
                32'(ref_y(sa[k-1], ss[k-1])));
            chk($sformatf("str_st_%0d", k), 32'(out_sticky),
                32'(ref_sticky(sa[k-1], ss[k-1])));
         end else begin
            chk("str_fill", 32'(out_valid), 32'd0);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("str_last_valid", 32'(out_valid), 32'd1);
      chk("str_last_y", 32'(out_y), 32'(ref_y(sa[19], ss[19])));
      chk("str_last_count", 32'(count), 32'd0);
      tick();
      chk("str_end_valid", 32'(out_valid), 32'd0);

      // 6: reset with queued and held data
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a     = 11'h400 | 11'(i);
         in_s     = 4'd0;
         tick();
      end
      in_valid = 1'b0;
      chk("mid_pre_count", 32'(count), 32'd3);
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b0;
      tick();
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", 32'(out_y), 32'd0);
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mid_after_valid_%0d", i), 32'(out_valid), 32'd0);
         chk($sformatf("mid_after_count_%0d", i), 32'(count), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
